// File: rtl/serial_sub_mux.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor slice per clock via 4:1 mux selection.
// Define SERIAL_SUB_OVF_EN to add a registered signed-overflow output (ovf).
module serial_sub_mux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             nb;

  // Running borrow is the mux data input; operand bits select the slice outputs.
  always_comb begin
    d  = br;
    nb = br;
    case ({sa[0], sb[0]})
      2'b00: begin d = br;  nb = br;   end
      2'b01: begin d = ~br; nb = 1'b1; end
      2'b10: begin d = ~br; nb = 1'b0; end
      default: begin d = br; nb = br;  end
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          diff <= {d, diff[WIDTH-1:1]};
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          br   <= nb;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            bout  <= nb;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into vs. out of the MSB slice differ exactly on signed overflow.
            ovf   <= br ^ nb;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_mux.sv
// Directed bench for serial_sub_mux with a result scoreboard and immediate-assertion checks.
module tb_serial_sub_mux;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int passes = 0;
  int total  = 0;

  // {ovf, bout, diff}
  logic [WIDTH+1:0] sb_q[$];

  serial_sub_mux #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic bi);
    logic [WIDTH:0] full;
    int             sr;
    logic           o;
    full = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    sr   = int'($signed(x)) - int'($signed(y)) - int'(bi);
    o    = (sr < -(2 ** (WIDTH - 1))) || (sr > (2 ** (WIDTH - 1)) - 1);
    return {o, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  task automatic compare_result(input string tag);
    logic [WIDTH+1:0] e;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, " diff"}, 32'(diff), 32'(e[WIDTH-1:0]));
    check({tag, " bout"}, 32'(bout), 32'(e[WIDTH]));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(e[WIDTH+1]));
`endif
  endtask

  task automatic do_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic bi);
    int cycles;
    int busy_cnt;
    a = x; b = y; bin = bi; start = 1'b1;
    sb_q.push_back(model(x, y, bi));
    tick();
    start = 1'b0;
    a = ~x; b = ~y; bin = ~bi;
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 4 * WIDTH) begin
      if (busy) busy_cnt++;
      tick();
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'(WIDTH));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, " busy in done"}, 32'(busy), 32'd0);
    compare_result(tag);
    tick();
    check({tag, " done one-shot"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   done_cnt;
    int   done_t[$];
    logic [WIDTH-1:0] ta;
    logic [WIDTH-1:0] tb;
    logic             tbin;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif

    do_op("100-37", 8'd100, 8'd37, 1'b0);
    do_op("5-10", 8'd5, 8'd10, 1'b0);
    do_op("0-0-1", 8'd0, 8'd0, 1'b1);
    do_op("ff-ff-1", 8'hFF, 8'hFF, 1'b1);

    // Held start with operands churning every cycle: only the accepting edges matter.
    done_cnt = 0;
    start = 1'b1;
    for (int t = 0; t < 2 * (WIDTH + 2); t++) begin
      ta   = WIDTH'(t * 37 + 11);
      tb   = WIDTH'(t * 53 + 5);
      tbin = t[0];
      a = ta; b = tb; bin = tbin;
      if (t == 0 || t == WIDTH + 2) sb_q.push_back(model(ta, tb, tbin));
      tick();
      if (done) begin
        done_cnt++;
        done_t.push_back(t);
        compare_result("held start");
      end
    end
    start = 1'b0;
    for (int t = 0; t < WIDTH + 4; t++) begin
      tick();
      if (done) done_cnt++;
    end
    check("held start done count", 32'(done_cnt), 32'd2);
    if (done_t.size() == 2)
      check("held start spacing", 32'(done_t[1] - done_t[0]), 32'(WIDTH + 2));
    else
      check("held start done edges", 32'(done_t.size()), 32'd2);

    // Reset at the 4th SHIFT edge aborts with no done.
    a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort done", 32'(done), 32'd0);
    done_cnt = 0;
    for (int t = 0; t < WIDTH + 4; t++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    check("abort no activity", 32'(done_cnt), 32'd0);
    do_op("aa-55", 8'hAA, 8'h55, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    do_op("80-01", 8'h80, 8'h01, 1'b0);
    do_op("7f-ff", 8'h7F, 8'hFF, 1'b0);
    do_op("10-01", 8'h10, 8'h01, 1'b0);
`endif

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_sub_mux.md
Name: serial_sub_mux

Overview:
- Bit-serial N-bit subtractor that computes diff = a - b - bin, LSB first, one bit per clock.
- Each bit slice is a full subtractor. Its difference and borrow are selected by 4:1 mux logic indexed by {a_bit, b_bit}, with the running borrow as the mux data input.
- Acts as the subtract-direction counterpart to the mux-based full adder datapath.
- Used where area matters more than latency, e.g. small ALUs and counters that compare by subtraction.

Parameters:
- WIDTH, 8, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when result is valid.
- diff  output  WIDTH  result register.
- bout  output  1  final borrow out of MSB (1 = unsigned a < b + bin).

Behaviour:
- Reset: on a rising edge with rst=1, all state returns to reset values.
  - state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, bit counter and borrow flop are cleared.
  - rst has priority over every other input, including in mid-operation. An aborted operation produces no done pulse.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: load sa<=a, sb<=b, br<=bin, cnt<=0; go to SHIFT.
  - diff and bout keep their last values until the next accepted start.
- SHIFT (busy=1), once per cycle:
  - d = sa[0] ^ sb[0] ^ br.
  - nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - Mux form, selecting on {sa[0],sb[0]}:
    - d: 00 -> br, 01 -> ~br, 10 -> ~br, 11 -> br.
    - nb: 00 -> br, 01 -> 1, 10 -> 0, 11 -> br.
  - Updates: diff <= {d, diff[WIDTH-1:1]}, sa >>= 1, sb >>= 1, br <= nb, cnt <= cnt+1.
  - When cnt == WIDTH-1, that bit is the final one. Go to DONE and latch bout <= nb.
- DONE:
  - done=1 for exactly this cycle, busy=0.
  - Next state is IDLE unconditionally. start is ignored in DONE.
- Latency: if start is sampled at edge k, SHIFT spans edges k+1 .. k+WIDTH. done is high during the cycle after edge k+WIDTH. A new start is accepted no earlier than edge k+WIDTH+2.
- start while busy or in DONE: ignored. It has no effect on the operands or the result.
- diff is cleared at the start of SHIFT only through shifting. After an accepted start, intermediate diff values are not valid until done.
- All arithmetic is modulo 2^WIDTH. bout reflects the unsigned borrow.
- a, b and bin may change freely after the start edge; only the captured copies are used.
- cnt is clog2(WIDTH) bits wide; there is no wrap-around beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered.
  - Reset value 0.
  - Updated in the same cycle as bout: ovf <= br_in_msb ^ nb_msb, where br_in_msb is the borrow into the MSB slice. This is the signed two's-complement overflow of a - b - bin.
  - Held until the next accepted start.
- Undefined:
  - No ovf port and no extra flop.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, rst held 2 cycles then released -> busy=0, done=0, diff=0x00, bout=0 (and ovf=0 if enabled).
- a=100, b=37, bin=0, start one cycle -> busy high 8 cycles, then done pulse of 1 cycle, diff=63, bout=0.
- a=5, b=10, bin=0 -> diff=251 (0xFB), bout=1. Follow with a=0, b=0, bin=1 -> diff=0xFF, bout=1.
- Start asserted continuously from IDLE, with a/b changed every cycle during SHIFT -> only the first operands are used: exactly one done per WIDTH+2 cycles and the result matches the captured operands.
- rst asserted at the 4th SHIFT cycle of a=0xAA, b=0x55 -> next cycle is IDLE with busy=0, diff=0, and no done pulse. A fresh start afterwards gives diff=0x55, bout=0.
- With SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1, bout=1.
  - a=0x10, b=0x01 -> ovf=0.
